// File: rtl/mc_controller.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives the datapath control inputs, PC/IR strobes and retire counter.
module mc_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   output logic             ir_en,
   output logic             pc_en,
   output logic             W_en,
   output logic [1:0]       Wreg_sel,
   output logic [1:0]       Wdata_sel,
   output logic [2:0]       ALUop,
   output logic             ALUsrc,
   output logic             DM_sel,
   output logic             Branch,
   output logic             Jal,
   output logic             Jr,
   output logic [1:0]       EXT_sel,
   output logic             Shift_sel,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_cnt,
   output logic             illegal
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ill;

   logic [5:0] w_op;
   logic [5:0] w_fn;
   logic       w_rtype;
   logic       w_addu, w_subu, w_jr, w_nop;
   logic       w_ori, w_lw, w_sw, w_beq, w_lui, w_jal;
   logic       w_bad;
   logic       w_unused;

   logic       w_ir_en, w_pc, w_wen, w_dm;
   logic       w_br, w_jal_sel, w_jr_sel;

   assign w_op     = instr[31:26];
   assign w_fn     = instr[5:0];
   assign w_unused = ^instr[25:6];
   assign w_rtype  = (w_op == 6'b000000);
   assign w_addu   = w_rtype && (w_fn == 6'b100001);
   assign w_subu   = w_rtype && (w_fn == 6'b100011);
   assign w_jr     = w_rtype && (w_fn == 6'b001000);
   assign w_nop    = w_rtype && (w_fn == 6'b000000);
   assign w_ori    = (w_op == 6'b001101);
   assign w_lw     = (w_op == 6'b100011);
   assign w_sw     = (w_op == 6'b101011);
   assign w_beq    = (w_op == 6'b000100);
   assign w_lui    = (w_op == 6'b001111);
   assign w_jal    = (w_op == 6'b000011);
   assign w_bad    = !(w_addu || w_subu || w_jr || w_nop ||
                       w_ori || w_lw || w_sw || w_beq ||
                       w_lui || w_jal);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
         r_ill   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_pc)
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (r_state == S_DECODE && w_bad)
            r_ill <= 1'b1;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_ir_en   = 1'b0;
      w_pc      = 1'b0;
      w_wen     = 1'b0;
      w_dm      = 1'b0;
      w_br      = 1'b0;
      w_jal_sel = 1'b0;
      w_jr_sel  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_en = 1'b1;
            w_next  = S_DECODE;
         end
         S_DECODE: begin
            if (w_jal) begin
               w_wen     = 1'b1;
               w_jal_sel = 1'b1;
               w_pc      = 1'b1;
               w_next    = S_FETCH;
            end else if (w_jr) begin
               w_jr_sel = 1'b1;
               w_pc     = 1'b1;
               w_next   = S_FETCH;
            end else if (w_nop || w_bad) begin
               w_pc   = 1'b1;
               w_next = S_FETCH;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_beq) begin
               w_br   = 1'b1;
               w_pc   = 1'b1;
               w_next = S_FETCH;
            end else if (w_lw || w_sw) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            if (w_sw) begin
               w_dm   = 1'b1;
               w_pc   = 1'b1;
               w_next = S_FETCH;
            end else begin
               w_next = S_WB;
            end
         end
         S_WB: begin
            w_wen  = 1'b1;
            w_pc   = 1'b1;
            w_next = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Selects depend only on the instruction once past FETCH.
   always_comb begin
      Wreg_sel  = 2'd0;
      Wdata_sel = 2'd0;
      ALUop     = 3'd0;
      ALUsrc    = 1'b0;
      EXT_sel   = 2'd0;
      Shift_sel = 1'b0;
      if (r_state != S_FETCH) begin
         unique case (1'b1)
            w_addu: Wreg_sel = 2'd1;
            w_subu: begin
               Wreg_sel = 2'd1;
               ALUop    = 3'd1;
            end
            w_ori: begin
               ALUop  = 3'd2;
               ALUsrc = 1'b1;
            end
            w_lw: begin
               ALUsrc    = 1'b1;
               EXT_sel   = 2'd1;
               Wdata_sel = 2'd1;
            end
            w_sw: begin
               ALUsrc  = 1'b1;
               EXT_sel = 2'd1;
            end
            w_beq: begin
               ALUop   = 3'd1;
               EXT_sel = 2'd1;
            end
            w_lui: begin
               Shift_sel = 1'b1;
               Wdata_sel = 2'd2;
            end
            w_jal: begin
               Wreg_sel  = 2'd2;
               Wdata_sel = 2'd3;
            end
            default: ;
         endcase
      end
   end

   assign ir_en     = w_ir_en;
   assign pc_en     = w_pc & ~reset;
   assign W_en      = w_wen & ~reset;
   assign DM_sel    = w_dm & ~reset;
   assign Branch    = w_br & ~reset;
   assign Jal       = w_jal_sel & ~reset;
   assign Jr        = w_jr_sel & ~reset;
   assign state     = r_state;
   assign instr_cnt = r_cnt;
   assign illegal   = r_ill;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed scenarios plus random instruction
// streams compared every cycle against a per-class sequence model.
module tb_mc_controller;

   localparam int C_ADDU = 0;
   localparam int C_SUBU = 1;
   localparam int C_JR   = 2;
   localparam int C_NOP  = 3;
   localparam int C_ORI  = 4;
   localparam int C_LW   = 5;
   localparam int C_SW   = 6;
   localparam int C_BEQ  = 7;
   localparam int C_LUI  = 8;
   localparam int C_JAL  = 9;
   localparam int C_ILL  = 10;

   logic        clk;
   logic        reset;
   logic [31:0] instr;

   logic        ir_en, pc_en, W_en, ALUsrc, DM_sel;
   logic        Branch, Jal, Jr, Shift_sel, illegal;
   logic [1:0]  Wreg_sel, Wdata_sel, EXT_sel;
   logic [2:0]  ALUop, state;
   logic [31:0] instr_cnt;

   logic        ir_en4, pc_en4, W_en4, ALUsrc4, DM_sel4;
   logic        Branch4, Jal4, Jr4, Shift_sel4, illegal4;
   logic [1:0]  Wreg_sel4, Wdata_sel4, EXT_sel4;
   logic [2:0]  ALUop4, state4;
   logic [3:0]  instr_cnt4;

   int          n_chk;
   int          n_fail;
   int          m_step;
   logic [31:0] m_cnt;
   logic        m_ill;

   mc_controller #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .instr(instr),
      .ir_en(ir_en), .pc_en(pc_en), .W_en(W_en),
      .Wreg_sel(Wreg_sel), .Wdata_sel(Wdata_sel),
      .ALUop(ALUop), .ALUsrc(ALUsrc), .DM_sel(DM_sel),
      .Branch(Branch), .Jal(Jal), .Jr(Jr),
      .EXT_sel(EXT_sel), .Shift_sel(Shift_sel),
      .state(state), .instr_cnt(instr_cnt), .illegal(illegal)
   );

   mc_controller #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .instr(instr),
      .ir_en(ir_en4), .pc_en(pc_en4), .W_en(W_en4),
      .Wreg_sel(Wreg_sel4), .Wdata_sel(Wdata_sel4),
      .ALUop(ALUop4), .ALUsrc(ALUsrc4), .DM_sel(DM_sel4),
      .Branch(Branch4), .Jal(Jal4), .Jr(Jr4),
      .EXT_sel(EXT_sel4), .Shift_sel(Shift_sel4),
      .state(state4), .instr_cnt(instr_cnt4), .illegal(illegal4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit legal_op(logic [5:0] op);
      return op == 6'h00 || op == 6'h0D || op == 6'h23 ||
             op == 6'h2B || op == 6'h04 || op == 6'h0F ||
             op == 6'h03;
   endfunction

   function automatic int classify(logic [31:0] w);
      case (w[31:26])
         6'h00: begin
            case (w[5:0])
               6'h21:   return C_ADDU;
               6'h23:   return C_SUBU;
               6'h08:   return C_JR;
               6'h00:   return C_NOP;
               default: return C_ILL;
            endcase
         end
         6'h0D:   return C_ORI;
         6'h23:   return C_LW;
         6'h2B:   return C_SW;
         6'h04:   return C_BEQ;
         6'h0F:   return C_LUI;
         6'h03:   return C_JAL;
         default: return C_ILL;
      endcase
   endfunction

   // Cycles from FETCH to the last state inclusive.
   function automatic int cls_len(int c);
      if (c == C_NOP || c == C_JR || c == C_JAL || c == C_ILL)
         return 2;
      if (c == C_BEQ) return 3;
      if (c == C_LW)  return 5;
      return 4;
   endfunction

   function automatic logic [2:0] st_of(int c, int k);
      if (k <= 2) return 3'(k);
      if (k == 3 && (c == C_LW || c == C_SW)) return 3'd3;
      return 3'd4;
   endfunction

   // {Wreg_sel, Wdata_sel, ALUop, ALUsrc, EXT_sel, Shift_sel}
   function automatic logic [10:0] sel_tab(int c);
      case (c)
         C_ADDU:  return {2'd1, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0};
         C_SUBU:  return {2'd1, 2'd0, 3'd1, 1'b0, 2'd0, 1'b0};
         C_ORI:   return {2'd0, 2'd0, 3'd2, 1'b1, 2'd0, 1'b0};
         C_LW:    return {2'd0, 2'd1, 3'd0, 1'b1, 2'd1, 1'b0};
         C_SW:    return {2'd0, 2'd0, 3'd0, 1'b1, 2'd1, 1'b0};
         C_BEQ:   return {2'd0, 2'd0, 3'd1, 1'b0, 2'd1, 1'b0};
         C_LUI:   return {2'd0, 2'd2, 3'd0, 1'b0, 2'd0, 1'b1};
         C_JAL:   return {2'd2, 2'd3, 3'd0, 1'b0, 2'd0, 1'b0};
         default: return 11'd0;
      endcase
   endfunction

   function automatic logic [31:0] gen(int c);
      logic [31:0] w;
      w = $urandom;
      case (c)
         C_ADDU: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
         C_SUBU: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
         C_JR:   begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
         C_NOP:  begin w[31:26] = 6'h00; w[5:0] = 6'h00; end
         C_ORI:  w[31:26] = 6'h0D;
         C_LW:   w[31:26] = 6'h23;
         C_SW:   w[31:26] = 6'h2B;
         C_BEQ:  w[31:26] = 6'h04;
         C_LUI:  w[31:26] = 6'h0F;
         C_JAL:  w[31:26] = 6'h03;
         default: begin
            while (classify(w) != C_ILL) w = $urandom;
         end
      endcase
      return w;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, compare every output, advance the model.
   task automatic step(logic rst, logic [31:0] w);
      int          c;
      logic [2:0]  s;
      logic        last;
      logic        on;
      logic [10:0] sel;
      @(negedge clk);
      reset = rst;
      instr = w;
      #1;
      c    = classify(w);
      s    = st_of(c, m_step);
      last = (m_step == cls_len(c) - 1);
      on   = !rst;
      sel  = (s != 3'd0) ? sel_tab(c) : 11'd0;
      chk("state", 32'(state), 32'(s));
      chk("ir_en", 32'(ir_en), 32'(s == 3'd0));
      chk("pc_en", 32'(pc_en), 32'(last && on));
      chk("W_en", 32'(W_en),
          32'(on && ((c == C_JAL && s == 3'd1) || s == 3'd4)));
      chk("DM_sel", 32'(DM_sel),
          32'(on && c == C_SW && s == 3'd3));
      chk("Branch", 32'(Branch), 32'(on && last && c == C_BEQ));
      chk("Jal", 32'(Jal), 32'(on && last && c == C_JAL));
      chk("Jr", 32'(Jr), 32'(on && last && c == C_JR));
      chk("sels", 32'({Wreg_sel, Wdata_sel, ALUop, ALUsrc,
                       EXT_sel, Shift_sel}), 32'(sel));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("instr_cnt", instr_cnt, m_cnt);
      chk("state4", 32'(state4), 32'(s));
      chk("instr_cnt4", 32'(instr_cnt4), 32'(m_cnt[3:0]));
      if (rst) begin
         m_step = 0;
         m_cnt  = 32'd0;
         m_ill  = 1'b0;
      end else begin
         if (m_step == 1 && c == C_ILL) m_ill = 1'b1;
         if (last) begin
            m_cnt  = m_cnt + 32'd1;
            m_step = 0;
         end else begin
            m_step = m_step + 1;
         end
      end
   endtask

   task automatic run_instr(logic [31:0] w, bit rnd_rst);
      int n;
      n = cls_len(classify(w));
      for (int k = 0; k < n; k++) begin
         if (rnd_rst && $urandom_range(0, 59) == 0) begin
            step(1'b1, w);
            return;
         end
         step(1'b0, w);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      m_step = 0;
      m_cnt  = 32'd0;
      m_ill  = 1'b0;
      reset  = 1'b1;
      instr  = 32'd0;

      step(1'b1, 32'd0);
      step(1'b1, 32'd0);

      // Reset held three cycles while addu is in WB.
      for (int k = 0; k < 3; k++) step(1'b0, 32'h00221821);
      for (int k = 0; k < 3; k++) step(1'b1, 32'h00221821);
      settle();
      chk("post_reset_state", 32'(state), 32'd0);
      chk("post_reset_cnt", instr_cnt, 32'd0);

      run_instr(32'h00221821, 1'b0);
      run_instr(32'h8C040008, 1'b0);
      settle();
      chk("cnt_after_addu_lw", instr_cnt, 32'd2);

      run_instr(32'hAC040004, 1'b0);
      run_instr(32'h10000003, 1'b0);
      run_instr(32'h0C000C00, 1'b0);
      run_instr(32'h03E00008, 1'b0);
      settle();
      chk("cnt_after_ctrl", instr_cnt, 32'd6);

      run_instr(32'hFC000000, 1'b0);
      settle();
      chk("illegal_set", 32'(illegal), 32'd1);
      run_instr(32'h00221821, 1'b0);
      run_instr(32'h3C011234, 1'b0);
      settle();
      chk("illegal_sticky", 32'(illegal), 32'd1);
      chk("cnt_after_ill", instr_cnt, 32'd9);

      step(1'b1, 32'd0);
      for (int k = 0; k < 17; k++) run_instr(32'd0, 1'b0);
      settle();
      chk("cnt4_wrap", 32'(instr_cnt4), 32'd1);
      chk("cnt32_17", instr_cnt, 32'd17);

      for (int k = 0; k < 500; k++)
         run_instr(gen($urandom_range(0, 10)), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control unit that drives the control-input side of the CPU datapath: register-write select, write-data select, GRF write enable, ALU op, ALU source, DM write enable, branch/jal/jr, EXT and Shift selects.
- It consumes the 32-bit instruction held in the instruction register and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It also issues the PC-update and IR-load strobes, and keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
instr  input  32  instruction from IR; stable from DECODE to end of instruction
ir_en  output  1  load IR from IM this cycle
pc_en  output  1  update PC this cycle
W_en  output  1  GRF write enable
Wreg_sel  output  2  0=rt, 1=rd, 2=$31
Wdata_sel  output  2  0=ALU, 1=DM, 2=Shift, 3=PC+4
ALUop  output  3  0=add, 1=sub, 2=or
ALUsrc  output  1  0=RD2, 1=EXT
DM_sel  output  1  DM write enable
Branch  output  1  beq PC select
Jal  output  1  jal PC select
Jr  output  1  jr PC select
EXT_sel  output  2  0=zero-ext, 1=sign-ext
Shift_sel  output  1  0=<<2 (branch offset), 1=<<16 (lui)
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
instr_cnt  output  CNT_W  instructions retired
illegal  output  1  sticky: unsupported opcode/funct decoded

Behaviour:
- The only registers are the state register, instr_cnt and illegal. All control outputs are Moore functions of state plus instr.
- Reset: state=FETCH, instr_cnt=0, illegal=0. While reset=1, W_en, DM_sel and pc_en are forced to 0 regardless of state.
- Reset mid-instruction returns to FETCH on the next edge; the partial instruction is abandoned and not counted.
- Default output value is 0 unless listed below. Data-path selects (Wreg_sel, Wdata_sel, ALUop, ALUsrc, EXT_sel, Shift_sel) are held valid from DECODE through the last state of the instruction.
- Decode:
  - opcode 000000 with funct 100001 = addu; funct 100011 = subu; funct 001000 = jr; funct 000000 = nop.
  - Other opcodes: 001101 = ori; 100011 = lw; 101011 = sw; 000100 = beq; 001111 = lui; 000011 = jal.
  - Anything else: illegal <= 1 in DECODE, then the instruction retires as a nop.
- FETCH: ir_en=1; next state DECODE.
- DECODE:
  - jal: W_en=1, Wreg_sel=2, Wdata_sel=3, Jal=1, pc_en=1 -> FETCH.
  - jr: Jr=1, pc_en=1 -> FETCH.
  - nop/illegal: pc_en=1 -> FETCH.
  - All others -> EXEC.
- EXEC:
  - addu: ALUop=0, ALUsrc=0.
  - subu: ALUop=1, ALUsrc=0.
  - ori: ALUop=2, ALUsrc=1, EXT_sel=0.
  - lw/sw: ALUop=0, ALUsrc=1, EXT_sel=1.
  - lui: EXT_sel=0, Shift_sel=1.
  - beq: ALUop=1, ALUsrc=0, EXT_sel=1, Shift_sel=0, Branch=1, pc_en=1 -> FETCH.
  - Next state: lw/sw -> MEM; addu/subu/ori/lui -> WB.
- MEM:
  - sw: DM_sel=1, pc_en=1 -> FETCH.
  - lw: DM_sel=0 -> WB.
- WB: W_en=1, pc_en=1 -> FETCH.
  - addu/subu: Wreg_sel=1, Wdata_sel=0.
  - ori: Wreg_sel=0, Wdata_sel=0.
  - lw: Wreg_sel=0, Wdata_sel=1.
  - lui: Wreg_sel=0, Wdata_sel=2.
- Latency in cycles, FETCH to last state inclusive: jal/jr/nop 2; beq 3; addu/subu/ori/lui/sw 4; lw 5.
- pc_en is asserted exactly once per instruction, in its last state. Branch/Jal/Jr are asserted only together with pc_en, so PC_sel defaults to PC+4.
- instr_cnt increments on every edge where pc_en=1 and reset=0; wraps modulo 2^CNT_W.
- W_en and DM_sel are never both 1. ir_en is never 1 outside FETCH.

Test Plan:
- Reset held 3 cycles in WB of addu -> W_en=0 and pc_en=0 during reset; state=0, instr_cnt=0 after; ir_en=1 in first post-reset cycle.
- Stream addu $3,$1,$2 (0x00221821) then lw $4,8($0) (0x8C040008) -> state trace 0,1,2,4 then 0,1,2,3,4. W_en high in both WBs: first with Wreg_sel=1/Wdata_sel=0, second with Wreg_sel=0/Wdata_sel=1. instr_cnt=2.
- sw (0xAC040004) -> DM_sel=1 only in state 3, W_en=0 throughout, pc_en in state 3; beq (0x10000003) -> Branch=1 and pc_en=1 in state 2, 3-cycle latency.
- jal 0x0C000C00 -> in DECODE: W_en=1, Wreg_sel=2, Wdata_sel=3, Jal=1, pc_en=1; jr $31 (0x03E00008) -> Jr=1, pc_en=1, 2 cycles each.
- Opcode 111111 (0xFC000000) -> illegal=1 from the cycle after DECODE and sticky across further legal instructions; retires in 2 cycles, W_en/DM_sel never asserted.
- CNT_W=4, run 17 nops -> instr_cnt wraps 15->0 and reads 1 at end.
